hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order pipeline: tracks in-flight register writes
//  across DEPTH stages between decode and writeback. Generates stall, data_hazard (bubble insert) and
//  control_hazard (squash window after a taken jump), plus per-operand forwarding selects. Sits beside
//  decode; its outputs drive the fetch stall, the decode squash and the ALU operand muxes.
// PARAMETERS
//  NREGS      32  architectural registers; AW = $clog2(NREGS); register 0 is hard-wired zero, never tracked
//  DEPTH      3   in-flight stages tracked (entry 0 = youngest, DEPTH-1 = at writeback); 1..8
//  FWD_EN     1   1: bypass from any tracked stage; 0: every RAW match raises data_hazard
//  LOAD_DIST  2   load result is forwardable only from entry index >= LOAD_DIST-1; 1..DEPTH
//  SQUASH_N   1   cycles control_hazard stays high after a taken jump; 1..7
// PORTS
//  clk          in   1            clock, rising edge
//  rst          in   1            asynchronous reset, active-low
//  issue_valid  in   1            decode presents an instruction this cycle
//  issue_wr     in   1            instruction writes a register
//  issue_load   in   1            instruction is a load (result from data memory)
//  issue_rd     in   AW           destination register
//  src0, src1   in   AW           source registers
//  src0_used    in   1            src0 actually read (likewise src1_used for src1)
//  src1_used    in   1
//  jump_taken   in   1            taken branch/jump resolved this cycle
//  dmem_ready   in   1            data memory ready
//  imem_ready   in   1            instruction memory ready
//  stall        out  1            freeze whole pipeline
//  data_hazard  out  1            hold fetch/decode, inject bubble
//  control_hazard out 1           squash instruction in decode
//  fwd_sel0     out  $clog2(DEPTH+1)  0 = register file, k = result of entry k-1 (fwd_sel1 likewise)
//  fwd_sel1     out  $clog2(DEPTH+1)
// BEHAVIOUR
//  - Reset (rst=0, async): all entries invalid, squash counter 0; all outputs 0 while rst=0.
//  - stall = ~dmem_ready | (jump_taken & ~imem_ready), combinational. While stall=1 entries and counter hold.
//  - Entry = {valid, rd, load}. Each non-stall edge: entry i -> i+1, entry DEPTH-1 retires; entry 0 loads
//    {issue_valid & issue_wr & rd!=0 & ~data_hazard & ~control_hazard, issue_rd, issue_load} (bubble otherwise).
//  - Match: srcN_used & srcN!=0 & entry k valid & entry k rd==srcN. Youngest (lowest k) match wins.
//  - FWD_EN=1: if winning entry is load and k < LOAD_DIST-1 -> data_hazard=1, fwd_selN=0; else fwd_selN=k+1.
//    FWD_EN=0: any match -> data_hazard=1; fwd_selN always 0.
//  - data_hazard and fwd_sel are combinational; both forced 0 while control_hazard=1 (decode is squashed).
//  - Squash counter: non-stall edge with jump_taken loads SQUASH_N; otherwise decrements if nonzero.
//    control_hazard = (counter!=0) | jump_taken. Taken jump inside an open window reloads SQUASH_N.
//  - Simultaneous jump_taken and data_hazard: control_hazard wins, bubble inserted, data_hazard reads 0.
//  - Reset mid-operation clears all in-flight state immediately; first edge after release sees empty board.
// STRUCTURE
//  - Shared package/header: fwd select encodings (FWD_RF=0), LD_* writeback codes, AW derivation macro.
//  - One sub-module: hazard_entry (one tracked stage, shift/hold/clear, match compare), instanced DEPTH times.
//  - Top: priority encoder for youngest match, squash counter, stall logic.
// TESTING
//  1. Reset: rst=0 with jump_taken=1, src0 matching prior entry -> all outputs 0; after release board empty.
//  2. ALU RAW, DEPTH=3, FWD_EN=1: issue rd=5, next src0=5 -> fwd_sel0=1; one cycle later -> 2; then 3; then 0.
//  3. Load-use, LOAD_DIST=2: load rd=7, next src1=7 -> data_hazard=1 one cycle, then fwd_sel1=2, no further stall.
//  4. x0 and unused: issue rd=0, src0=0 -> no hazard; src0_used=0 with match -> fwd_sel0=0.
//  5. Jump, SQUASH_N=2: jump_taken one cycle -> control_hazard high 3 cycles, squashed entries invalid.
//  6. dmem_ready=0 for 4 cycles with entry rd=9 at k=0 -> stall=1, fwd_sel stays 1, no shift, counter frozen.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard/forwarding scoreboard: forward-select
// encoding, writeback-source codes and register-index width derivation.
package hazard_scoreboard_pkg;

    // Forward select value meaning "read the register file"
    localparam int FWD_RF = 0;

    // Writeback source carried in each tracked entry
    localparam logic LD_ALU = 1'b0;
    localparam logic LD_MEM = 1'b1;

    // Squash counter width covers SQUASH_N up to 7
    localparam int SQ_W = 3;

    function automatic int aw_of(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/hazard_entry.sv
// One tracked in-flight stage: holds {valid, rd, load}, shifts on advance,
// clears on reset, and reports whether it supplies either source operand.
module hazard_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift,
    input  logic          in_valid,
    input  logic [AW-1:0] in_rd,
    input  logic          in_load,
    input  logic [AW-1:0] src0,
    input  logic          src0_used,
    input  logic [AW-1:0] src1,
    input  logic          src1_used,
    output logic          valid,
    output logic [AW-1:0] rd,
    output logic          load,
    output logic          match0,
    output logic          match1
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            rd    <= '0;
            load  <= LD_ALU;
        end else if (shift) begin
            valid <= in_valid;
            rd    <= in_rd;
            load  <= in_load;
        end
    end

    // Register 0 is hard-wired zero, so it never produces a dependency
    assign match0 = valid & src0_used & (src0 != '0) & (rd == src0);
    assign match1 = valid & src1_used & (src1 != '0) & (rd == src1);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller beside decode: tracks DEPTH in-flight register
// writes and produces stall, bubble, squash and per-operand bypass selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int NREGS     = 32,
    parameter  int DEPTH     = 3,
    parameter  int FWD_EN    = 1,
    parameter  int LOAD_DIST = 2,
    parameter  int SQUASH_N  = 1,
    localparam int AW        = aw_of(NREGS),
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_wr,
    input  logic          issue_load,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] src0,
    input  logic [AW-1:0] src1,
    input  logic          src0_used,
    input  logic          src1_used,
    input  logic          jump_taken,
    input  logic          dmem_ready,
    input  logic          imem_ready,
    output logic          stall,
    output logic          data_hazard,
    output logic          control_hazard,
    output logic [SW-1:0] fwd_sel0,
    output logic [SW-1:0] fwd_sel1
);

    logic            stall_raw;
    logic            advance;
    logic            squash;
    logic            issue_ok;
    logic [SQ_W-1:0] sq_cnt;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_load;
    logic [AW-1:0]    ent_rd [DEPTH];
    logic [DEPTH-1:0] nxt_valid;
    logic [DEPTH-1:0] nxt_load;
    logic [AW-1:0]    nxt_rd [DEPTH];
    logic [DEPTH-1:0] match0;
    logic [DEPTH-1:0] match1;

    logic            haz0, haz1;
    logic [SW-1:0]   sel0, sel1;

    assign stall_raw = ~dmem_ready | (jump_taken & ~imem_ready);
    assign advance   = ~stall_raw;
    assign squash    = (sq_cnt != '0) | jump_taken;

    // Everything reads 0 while reset is held, including the combinational paths
    assign stall          = rst & stall_raw;
    assign control_hazard = rst & squash;
    assign data_hazard    = rst & ~squash & (haz0 | haz1);
    assign fwd_sel0       = (rst & ~squash) ? sel0 : SW'(FWD_RF);
    assign fwd_sel1       = (rst & ~squash) ? sel1 : SW'(FWD_RF);

    assign issue_ok = issue_valid & issue_wr & (issue_rd != '0) & ~data_hazard & ~control_hazard;

    always_comb begin
        nxt_valid[0] = issue_ok;
        nxt_rd[0]    = issue_rd;
        nxt_load[0]  = issue_load;
        for (int i = 1; i < DEPTH; i++) begin
            nxt_valid[i] = ent_valid[i-1];
            nxt_rd[i]    = ent_rd[i-1];
            nxt_load[i]  = ent_load[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        hazard_entry #(.AW(AW)) u_entry (
            .clk       (clk),
            .rst       (rst),
            .shift     (advance),
            .in_valid  (nxt_valid[i]),
            .in_rd     (nxt_rd[i]),
            .in_load   (nxt_load[i]),
            .src0      (src0),
            .src0_used (src0_used),
            .src1      (src1),
            .src1_used (src1_used),
            .valid     (ent_valid[i]),
            .rd        (ent_rd[i]),
            .load      (ent_load[i]),
            .match0    (match0[i]),
            .match1    (match1[i])
        );
    end

    // Scan oldest to youngest so the youngest matching entry has the last word
    function automatic void resolve(input  logic [DEPTH-1:0] hit,
                                    input  logic [DEPTH-1:0] is_load,
                                    output logic             haz,
                                    output logic [SW-1:0]    sel);
        haz = 1'b0;
        sel = SW'(FWD_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                if (FWD_EN == 0 || (is_load[k] == LD_MEM && k < LOAD_DIST - 1)) begin
                    haz = 1'b1;
                    sel = SW'(FWD_RF);
                end else begin
                    haz = 1'b0;
                    sel = SW'(k + 1);
                end
            end
        end
    endfunction

    always_comb begin
        resolve(match0, ent_load, haz0, sel0);
        resolve(match1, ent_load, haz1, sel1);
    end

    // A taken jump (re)opens the squash window; stalled edges freeze it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_cnt <= '0;
        end else if (advance) begin
            if (jump_taken)
                sq_cnt <= SQ_W'(SQUASH_N);
            else if (sq_cnt != '0)
                sq_cnt <= sq_cnt - SQ_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a queue-based model of in-flight
// writes is compared every cycle, plus literal checks on key cycles.
module tb_hazard_scoreboard;

    localparam int NREGS     = 32;
    localparam int DEPTH     = 3;
    localparam int FWD_EN    = 1;
    localparam int LOAD_DIST = 2;
    localparam int SQUASH_N  = 2;
    localparam int AW        = $clog2(NREGS);
    localparam int SW        = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid, issue_wr, issue_load;
    logic [AW-1:0] issue_rd, src0, src1;
    logic          src0_used, src1_used;
    logic          jump_taken, dmem_ready, imem_ready;
    logic          stall, data_hazard, control_hazard;
    logic [SW-1:0] fwd_sel0, fwd_sel1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREGS(NREGS), .DEPTH(DEPTH), .FWD_EN(FWD_EN),
        .LOAD_DIST(LOAD_DIST), .SQUASH_N(SQUASH_N)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_load(issue_load),
        .issue_rd(issue_rd), .src0(src0), .src1(src1),
        .src0_used(src0_used), .src1_used(src1_used),
        .jump_taken(jump_taken), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .stall(stall), .data_hazard(data_hazard), .control_hazard(control_hazard),
        .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1)
    );

    // Model: the last DEPTH accepted issue slots, youngest first
    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          ld;
    } slot_t;

    slot_t hist[$];
    int    squash_left;

    function automatic void model_clear();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('0);
        squash_left = 0;
    endfunction

    function automatic void op_eval(input logic [AW-1:0] src, input logic used,
                                    output logic haz, output logic [SW-1:0] sel);
        haz = 1'b0;
        sel = '0;
        if (!used || src == 0) return;
        for (int k = 0; k < DEPTH; k++) begin
            if (hist[k].v && hist[k].rd == src) begin
                if (FWD_EN == 0) haz = 1'b1;
                else if (hist[k].ld && k < LOAD_DIST - 1) haz = 1'b1;
                else sel = SW'(k + 1);
                return;
            end
        end
    endfunction

    function automatic void model_eval(output logic e_st, output logic e_dh, output logic e_ch,
                                       output logic [SW-1:0] e_s0, output logic [SW-1:0] e_s1);
        logic h0, h1;
        e_st = 1'b0; e_dh = 1'b0; e_ch = 1'b0; e_s0 = '0; e_s1 = '0;
        if (!rst) return;
        e_st = !dmem_ready || (jump_taken && !imem_ready);
        e_ch = (squash_left > 0) || jump_taken;
        op_eval(src0, src0_used, h0, e_s0);
        op_eval(src1, src1_used, h1, e_s1);
        e_dh = h0 || h1;
        if (e_ch) begin
            e_dh = 1'b0; e_s0 = '0; e_s1 = '0;
        end
    endfunction

    function automatic void chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    always @(negedge rst) model_clear();

    always @(posedge clk) begin : model_update
        logic e_st, e_dh, e_ch;
        logic [SW-1:0] e_s0, e_s1;
        if (!rst) begin
            model_clear();
        end else begin
            model_eval(e_st, e_dh, e_ch, e_s0, e_s1);
            if (!e_st) begin
                hist.push_front(slot_t'{issue_valid && issue_wr && issue_rd != 0 && !e_dh && !e_ch,
                                        issue_rd, issue_load});
                void'(hist.pop_back());
                if (jump_taken) squash_left = SQUASH_N;
                else if (squash_left > 0) squash_left--;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic e_st, e_dh, e_ch;
        logic [SW-1:0] e_s0, e_s1;
        model_eval(e_st, e_dh, e_ch, e_s0, e_s1);
        chk("m_stall", stall, e_st);
        chk("m_data_hazard", data_hazard, e_dh);
        chk("m_control_hazard", control_hazard, e_ch);
        chk("m_fwd_sel0", fwd_sel0, e_s0);
        chk("m_fwd_sel1", fwd_sel1, e_s1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_wr = 1'b0; issue_load = 1'b0; issue_rd = '0;
        src0 = '0; src1 = '0; src0_used = 1'b0; src1_used = 1'b0;
        jump_taken = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic ld);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd; issue_load = ld;
    endtask

    initial begin
        model_clear();
        idle();
        tick(); tick();
        rst = 1'b1;

        // Reset: outputs forced low even with jump, dmem stall and a live match
        issue(4, 1'b0);
        tick(); idle(); src0 = 4; src0_used = 1'b1;
        #1 chk("t1_pre_fwd0", fwd_sel0, 1);
        tick();
        rst = 1'b0; jump_taken = 1'b1; dmem_ready = 1'b0; src0 = 4; src0_used = 1'b1;
        #1 chk("t1_rst_stall", stall, 0);
        chk("t1_rst_ch", control_hazard, 0);
        chk("t1_rst_dh", data_hazard, 0);
        chk("t1_rst_fwd0", fwd_sel0, 0);
        tick(); tick();
        idle(); rst = 1'b1; src0 = 4; src0_used = 1'b1;
        #1 chk("t1_post_fwd0", fwd_sel0, 0);
        chk("t1_post_ch", control_hazard, 0);

        // ALU RAW: bypass select walks 1, 2, 3 then falls back to the register file
        tick(); idle(); issue(5, 1'b0);
        tick(); idle(); src0 = 5; src0_used = 1'b1;
        #1 chk("t2_fwd0_k0", fwd_sel0, 1);
        tick(); #1 chk("t2_fwd0_k1", fwd_sel0, 2);
        tick(); #1 chk("t2_fwd0_k2", fwd_sel0, 3);
        tick(); #1 chk("t2_fwd0_retired", fwd_sel0, 0);

        // Load-use: one bubble, then forward from entry 1
        tick(); idle(); issue(7, 1'b1);
        tick(); idle(); issue(8, 1'b0); src1 = 7; src1_used = 1'b1;
        #1 chk("t3_dh", data_hazard, 1);
        chk("t3_fwd1_blocked", fwd_sel1, 0);
        tick();
        #1 chk("t3_dh_clear", data_hazard, 0);
        chk("t3_fwd1_k1", fwd_sel1, 2);
        tick(); idle(); src1 = 7; src1_used = 1'b1; src0 = 8; src0_used = 1'b1;
        #1 chk("t3_fwd1_k2", fwd_sel1, 3);
        chk("t3_fwd0_k0", fwd_sel0, 1);
        chk("t3_no_dh", data_hazard, 0);

        // x0 is never tracked; an unused source never forwards
        tick(); idle(); issue(0, 1'b0);
        tick(); idle(); src0 = 0; src0_used = 1'b1;
        #1 chk("t4_x0_dh", data_hazard, 0);
        chk("t4_x0_fwd0", fwd_sel0, 0);
        tick(); idle(); issue(10, 1'b0);
        tick(); idle(); src0 = 10; src0_used = 1'b0; src1 = 10; src1_used = 1'b1;
        #1 chk("t4_unused_fwd0", fwd_sel0, 0);
        chk("t4_used_fwd1", fwd_sel1, 1);

        // Taken jump: three squash cycles, squashed issues never enter the board
        tick(); idle(); issue(11, 1'b0); jump_taken = 1'b1; src0 = 10; src0_used = 1'b1;
        #1 chk("t5_ch0", control_hazard, 1);
        chk("t5_fwd0_forced", fwd_sel0, 0);
        tick(); idle(); issue(12, 1'b0);
        #1 chk("t5_ch1", control_hazard, 1);
        tick(); idle(); issue(13, 1'b0);
        #1 chk("t5_ch2", control_hazard, 1);
        tick(); idle(); src0 = 12; src0_used = 1'b1; src1 = 13; src1_used = 1'b1;
        #1 chk("t5_ch_done", control_hazard, 0);
        chk("t5_sq_fwd0", fwd_sel0, 0);
        chk("t5_sq_fwd1", fwd_sel1, 0);

        // dmem stall: board holds, rd=9 stays at entry 0
        tick(); idle(); issue(9, 1'b0);
        tick(); idle(); issue(14, 1'b0); src0 = 9; src0_used = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t6_stall", stall, 1);
            chk("t6_fwd0_hold", fwd_sel0, 1);
            tick();
        end
        idle(); src0 = 9; src0_used = 1'b1; src1 = 14; src1_used = 1'b1;
        #1 chk("t6_stall_off", stall, 0);
        chk("t6_fwd0_still_k0", fwd_sel0, 1);
        chk("t6_stalled_issue_dropped", fwd_sel1, 0);
        tick(); #1 chk("t6_fwd0_k1", fwd_sel0, 2);

        // Squash counter freezes across a dmem stall
        tick(); idle(); jump_taken = 1'b1;
        #1 chk("t6_jump_ch", control_hazard, 1);
        tick(); idle(); dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t6_frozen_ch", control_hazard, 1);
            tick();
        end
        idle();
        #1 chk("t6_resume_ch2", control_hazard, 1);
        tick(); #1 chk("t6_resume_ch1", control_hazard, 1);
        tick(); #1 chk("t6_resume_ch0", control_hazard, 0);

        // Jump while imem is not ready stalls and does not open a window
        tick(); idle(); jump_taken = 1'b1; imem_ready = 1'b0;
        #1 chk("t7_imem_stall", stall, 1);
        tick(); idle();
        #1 chk("t7_no_window", control_hazard, 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
